// File: rtl/wide_add_sched_pkg.sv
// Shared definitions for the time-shared wide adder: FSM encodings, chunk width
// and the chunk-index sequencing function.
package wide_add_sched_pkg;

   localparam int CHUNK_W = 16;
   localparam int IDX_W   = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // The index is stepped by a lookup, so the shared adder stays the only adder.
   function automatic logic [IDX_W-1:0] chunk_idx_next(input logic [IDX_W-1:0] k);
      case (k)
         2'd0:    return 2'd1;
         2'd1:    return 2'd2;
         2'd2:    return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/wide_add_sched_cla.sv
// 16-bit two-level carry-lookahead adder: four 4-bit groups with group
// generate/propagate feeding a second lookahead level.
module cla_group_16bits (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] sum,
   output logic        cout
);

   logic [15:0] g;
   logic [15:0] p;
   logic [15:0] c;
   logic [3:0]  gg;
   logic [3:0]  gp;
   logic [4:0]  gc;

   assign g = a & b;
   assign p = a ^ b;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_group
         localparam int B = 4 * gi;
         assign gg[gi] = g[B+3]
                       | (p[B+3] & g[B+2])
                       | (p[B+3] & p[B+2] & g[B+1])
                       | (p[B+3] & p[B+2] & p[B+1] & g[B]);
         assign gp[gi] = &p[B +: 4];
         assign c[B]   = gc[gi];
         assign c[B+1] = g[B] | (p[B] & gc[gi]);
         assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & gc[gi]);
         assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                       | (p[B+2] & p[B+1] & p[B] & gc[gi]);
      end
   endgenerate

   // Group carries are fully expanded from cin so no group waits on another.
   assign gc[0] = cin;
   assign gc[1] = gg[0] | (gp[0] & cin);
   assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
   assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                | (gp[2] & gp[1] & gp[0] & cin);
   assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                | (gp[3] & gp[2] & gp[1] & gg[0])
                | (gp[3] & gp[2] & gp[1] & gp[0] & cin);

   assign sum  = p ^ c;
   assign cout = gc[4];

endmodule

// File: rtl/wide_add_sched.sv
// Two-requester W-bit add/sub sharing one 16-bit CLA, one chunk per cycle, LSB first.
// Define WIDE_ADD_OVF_EN to compute signed overflow; otherwise rsp_ovf is tied 0.
module wide_add_sched
   import wide_add_sched_pkg::*;
#(
   parameter int CHUNKS = 2,
   localparam int W = CHUNK_W * CHUNKS
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req0_b,
   input  logic         req0_sub,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req1_b,
   input  logic         req1_sub,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [W-1:0] rsp_sum,
   output logic         rsp_co,
   output logic         rsp_id,
   output logic         rsp_ovf
);

   state_t             state_reg;
   state_t             state_next;
   logic [IDX_W-1:0]   k_reg;
   logic [W-1:0]       a_reg;
   logic [W-1:0]       b_reg;
   logic               carry_reg;
   logic               id_reg;
   logic               prio_reg;
   logic               co_reg;

   logic               grant_any;
   logic               grant_id;
   logic               last_chunk;
   logic [W-1:0]       a_sel;
   logic [W-1:0]       b_sel;
   logic               sub_sel;
   logic [CHUNK_W-1:0] op_a;
   logic [CHUNK_W-1:0] op_b;
   logic [CHUNK_W-1:0] chunk_sum;
   logic               chunk_co;

   assign last_chunk = (k_reg == IDX_W'(CHUNKS - 1));

   always_comb begin
      state_next = state_reg;
      grant_any  = 1'b0;
      grant_id   = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      case (state_reg)
         IDLE: begin
            // Ready is masked while rst is high even though the state is already IDLE.
            if (!rst && (req0_valid || req1_valid)) begin
               grant_any  = 1'b1;
               grant_id   = req0_valid ? (req1_valid ? prio_reg : 1'b0) : 1'b1;
               req0_ready = ~grant_id;
               req1_ready = grant_id;
               state_next = CALC;
            end
         end
         CALC: begin
            if (last_chunk) state_next = DONE;
         end
         DONE: begin
            if (rsp_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign a_sel   = grant_id ? req1_a   : req0_a;
   assign b_sel   = grant_id ? req1_b   : req0_b;
   assign sub_sel = grant_id ? req1_sub : req0_sub;

   always_comb begin
      op_a = '0;
      op_b = '0;
      for (int i = 0; i < CHUNKS; i++) begin
         if (k_reg == IDX_W'(i)) begin
            op_a = a_reg[i*CHUNK_W +: CHUNK_W];
            op_b = b_reg[i*CHUNK_W +: CHUNK_W];
         end
      end
   end

   cla_group_16bits u_cla (
      .a    (op_a),
      .b    (op_b),
      .cin  (carry_reg),
      .sum  (chunk_sum),
      .cout (chunk_co)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         k_reg     <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         carry_reg <= 1'b0;
         id_reg    <= 1'b0;
         prio_reg  <= 1'b0;
         co_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            IDLE: begin
               if (grant_any) begin
                  // Subtract is A + ~B + 1: the +1 enters as chunk 0's carry-in.
                  a_reg     <= a_sel;
                  b_reg     <= b_sel ^ {W{sub_sel}};
                  carry_reg <= sub_sel;
                  id_reg    <= grant_id;
                  prio_reg  <= ~grant_id;
                  k_reg     <= '0;
               end
            end
            CALC: begin
               carry_reg <= chunk_co;
               k_reg     <= last_chunk ? '0 : chunk_idx_next(k_reg);
               if (last_chunk) co_reg <= chunk_co;
            end
            default: ;
         endcase
      end
   end

   generate
      for (genvar gi = 0; gi < CHUNKS; gi++) begin : g_chunk
         logic [CHUNK_W-1:0] chunk_q;
         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               chunk_q <= '0;
            else if (state_reg == CALC && k_reg == IDX_W'(gi))
               chunk_q <= chunk_sum;
         end
         assign rsp_sum[gi*CHUNK_W +: CHUNK_W] = chunk_q;
      end
   endgenerate

`ifdef WIDE_ADD_OVF_EN
   logic ovf_reg;

   // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ovf_reg <= 1'b0;
      else if (state_reg == CALC && last_chunk)
         ovf_reg <= op_a[CHUNK_W-1] ^ op_b[CHUNK_W-1] ^ chunk_sum[CHUNK_W-1] ^ chunk_co;
   end

   assign rsp_ovf = ovf_reg;
`else
   assign rsp_ovf = 1'b0;
`endif

   assign rsp_valid = (state_reg == DONE);
   assign rsp_co    = co_reg;
   assign rsp_id    = id_reg;

endmodule
